// File: rtl/channel_err_inj_if.sv
// Symbol/control bundle between a stimulus source (master) and the channel error injector (slave).
interface channel_err_inj_if #(
  parameter int W     = 2,
  parameter int CNT_W = 16
);
  logic             valid_i;
  logic [W-1:0]     sym_i;
  logic [1:0]       mode_i;
  logic [W-1:0]     err_mask_i;
  logic [15:0]      thresh_i;
  logic             clear_i;
  logic             valid_o;
  logic [W-1:0]     sym_o;
  logic             err_o;
  logic [CNT_W-1:0] bit_err_ct_o;
  logic [CNT_W-1:0] sym_ct_o;

  modport master (
    output valid_i, sym_i, mode_i, err_mask_i, thresh_i, clear_i,
    input  valid_o, sym_o, err_o, bit_err_ct_o, sym_ct_o
  );

  modport slave (
    input  valid_i, sym_i, mode_i, err_mask_i, thresh_i, clear_i,
    output valid_o, sym_o, err_o, bit_err_ct_o, sym_ct_o
  );
endinterface

// File: rtl/channel_err_inj.sv
// Channel model: registers coded symbols and XOR-corrupts them with a periodic burst and/or LFSR pattern.
// Statistics counters exist only when CHANNEL_ERR_INJ_STATS_EN is defined; otherwise they read 0.
module channel_err_inj #(
  parameter int          W         = 2,
  parameter int          PERIOD    = 16,
  parameter int          BURST     = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  channel_err_inj_if.slave bus
);
  localparam int              POS_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int              PC_W      = $clog2(W + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PERIOD - 1);
  localparam logic [POS_W:0]  BURST_END = (POS_W + 1)'(BURST);
  localparam logic            HAS_BURST = (BURST > 0);
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;

  typedef enum logic {ST_BURST = 1'b0, ST_GAP = 1'b1} state_t;
  localparam state_t ST_INIT = HAS_BURST ? ST_BURST : ST_GAP;

  function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
    logic [PC_W-1:0] n;
    n = {PC_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s[0]) begin
      return {1'b0, s[15:1]} ^ LFSR_TAPS;
    end else begin
      return {1'b0, s[15:1]};
    end
  endfunction

  logic [POS_W-1:0] pos_r;
  state_t           state_r;
  logic [15:0]      lfsr_r;
  logic             valid_r;
  logic [W-1:0]     sym_r;
  logic             err_r;

  logic [POS_W-1:0] pos_cur_s;
  logic [POS_W-1:0] pos_nxt_s;
  state_t           state_cur_s;
  state_t           state_nxt_s;
  logic [15:0]      lfsr_cur_s;
  logic             hit_s;
  logic [W-1:0]     flip_s;

  // Clear takes effect before the same-cycle symbol, so it sees pos=0 and the seed.
  always_comb begin
    pos_cur_s   = pos_r;
    state_cur_s = state_r;
    lfsr_cur_s  = lfsr_r;
    if (bus.clear_i) begin
      pos_cur_s   = {POS_W{1'b0}};
      state_cur_s = ST_INIT;
      lfsr_cur_s  = LFSR_SEED;
    end else begin
      pos_cur_s   = pos_r;
      state_cur_s = state_r;
      lfsr_cur_s  = lfsr_r;
    end

    if (pos_cur_s == POS_LAST) begin
      pos_nxt_s = {POS_W{1'b0}};
    end else begin
      pos_nxt_s = pos_cur_s + POS_W'(1'b1);
    end

    case (state_cur_s)
      ST_BURST: state_nxt_s = ({1'b0, pos_nxt_s} >= BURST_END) ? ST_GAP : ST_BURST;
      ST_GAP:   state_nxt_s = (HAS_BURST && (pos_nxt_s == {POS_W{1'b0}})) ? ST_BURST : ST_GAP;
      default:  state_nxt_s = ST_INIT;
    endcase

    hit_s = (bus.mode_i[0] && (state_cur_s == ST_BURST)) ||
            (bus.mode_i[1] && (lfsr_cur_s < bus.thresh_i));
    if (hit_s) begin
      flip_s = bus.err_mask_i;
    end else begin
      flip_s = {W{1'b0}};
    end
  end

  // Pattern FSM, LFSR and registered symbol path; idle cycles freeze the pattern state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_r   <= {POS_W{1'b0}};
      state_r <= ST_INIT;
      lfsr_r  <= LFSR_SEED;
      valid_r <= 1'b0;
      sym_r   <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      valid_r <= bus.valid_i;
      if (bus.valid_i) begin
        pos_r   <= pos_nxt_s;
        state_r <= state_nxt_s;
        lfsr_r  <= lfsr_step(lfsr_cur_s);
        sym_r   <= bus.sym_i ^ flip_s;
        err_r   <= |flip_s;
      end else begin
        pos_r   <= pos_cur_s;
        state_r <= state_cur_s;
        lfsr_r  <= lfsr_cur_s;
        sym_r   <= sym_r;
        err_r   <= 1'b0;
      end
    end
  end

  assign bus.valid_o = valid_r;
  assign bus.sym_o   = sym_r;
  assign bus.err_o   = err_r;

`ifdef CHANNEL_ERR_INJ_STATS_EN
  localparam int               SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bit_ct_r;
  logic [CNT_W-1:0] sym_ct_r;
  logic [CNT_W-1:0] bit_base_s;
  logic [CNT_W-1:0] sym_base_s;
  logic [SUM_W-1:0] bit_sum_s;
  logic [CNT_W-1:0] bit_nxt_s;
  logic [CNT_W-1:0] sym_nxt_s;

  // Saturating next values, computed from the post-clear base.
  always_comb begin
    if (bus.clear_i) begin
      bit_base_s = {CNT_W{1'b0}};
      sym_base_s = {CNT_W{1'b0}};
    end else begin
      bit_base_s = bit_ct_r;
      sym_base_s = sym_ct_r;
    end
    bit_sum_s = SUM_W'(bit_base_s) + SUM_W'(popcount(flip_s));
    if (bit_sum_s > SUM_W'(CNT_MAX)) begin
      bit_nxt_s = CNT_MAX;
    end else begin
      bit_nxt_s = bit_sum_s[CNT_W-1:0];
    end
    if (sym_base_s == CNT_MAX) begin
      sym_nxt_s = CNT_MAX;
    end else begin
      sym_nxt_s = sym_base_s + CNT_W'(1'b1);
    end
  end

  // Statistics registers update on the same edge as the symbol output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_r <= {CNT_W{1'b0}};
      sym_ct_r <= {CNT_W{1'b0}};
    end else if (bus.valid_i) begin
      bit_ct_r <= bit_nxt_s;
      sym_ct_r <= sym_nxt_s;
    end else begin
      bit_ct_r <= bit_base_s;
      sym_ct_r <= sym_base_s;
    end
  end

  assign bus.bit_err_ct_o = bit_ct_r;
  assign bus.sym_ct_o     = sym_ct_r;
`else
  assign bus.bit_err_ct_o = {CNT_W{1'b0}};
  assign bus.sym_ct_o     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_channel_err_inj.sv
// Self-checking bench: three channel_err_inj configurations driven in lockstep against a reference model.
module tb_channel_err_inj;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef CHANNEL_ERR_INJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        valid, clear;
  logic [1:0]  sym, mode, mask;
  logic [15:0] thresh;

  channel_err_inj_if #(.W(2), .CNT_W(16)) if_a ();
  channel_err_inj_if #(.W(2), .CNT_W(4))  if_b ();
  channel_err_inj_if #(.W(2), .CNT_W(16)) if_c ();

  assign if_a.valid_i = valid;  assign if_b.valid_i = valid;  assign if_c.valid_i = valid;
  assign if_a.sym_i = sym;      assign if_b.sym_i = sym;      assign if_c.sym_i = sym;
  assign if_a.mode_i = mode;    assign if_b.mode_i = mode;    assign if_c.mode_i = mode;
  assign if_a.err_mask_i = mask; assign if_b.err_mask_i = mask; assign if_c.err_mask_i = mask;
  assign if_a.thresh_i = thresh; assign if_b.thresh_i = thresh; assign if_c.thresh_i = thresh;
  assign if_a.clear_i = clear;  assign if_b.clear_i = clear;  assign if_c.clear_i = clear;

  channel_err_inj #(.W(2), .PERIOD(8), .BURST(2), .LFSR_SEED(16'hACE1), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  channel_err_inj #(.W(2), .PERIOD(4), .BURST(4), .LFSR_SEED(16'hACE1), .CNT_W(4))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  channel_err_inj #(.W(2), .PERIOD(16), .BURST(1), .LFSR_SEED(16'hACE1), .CNT_W(16))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct packed {
    logic        valid;
    logic [1:0]  sym;
    logic        err;
    logic [15:0] bct;
    logic [15:0] sct;
  } exp_t;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [1:0] xs;
    logic       xe;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int per_p[3]  = '{8, 4, 16};
  int bur_p[3]  = '{2, 4, 1};
  int cmax_p[3] = '{65535, 15, 65535};

  int          m_pos[3];
  logic [15:0] m_lfsr[3];
  int          m_b[3];
  int          m_s[3];
  logic [1:0]  m_sym[3];

  task automatic check(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h exp %0h", name, id, got, exp);
    end
  endtask

  function automatic exp_t observe(input int id);
    exp_t g;
    case (id)
      0: g = {if_a.valid_o, if_a.sym_o, if_a.err_o, if_a.bit_err_ct_o, if_a.sym_ct_o};
      1: g = {if_b.valid_o, if_b.sym_o, if_b.err_o, 16'(if_b.bit_err_ct_o), 16'(if_b.sym_ct_o)};
      default: g = {if_c.valid_o, if_c.sym_o, if_c.err_o, if_c.bit_err_ct_o, if_c.sym_ct_o};
    endcase
    return g;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 3; id++) begin
      m_pos[id] = 0; m_lfsr[id] = 16'hACE1; m_b[id] = 0; m_s[id] = 0; m_sym[id] = 2'b00;
    end
  endtask

  // Reference behaviour written from the symbol index, not from an FSM.
  task automatic model_push(input int id);
    exp_t       e;
    bit         hit;
    logic [1:0] flip;
    if (clear) begin
      m_pos[id] = 0; m_lfsr[id] = 16'hACE1; m_b[id] = 0; m_s[id] = 0;
    end
    e.err = 1'b0;
    if (valid) begin
      hit  = (mode[0] && (m_pos[id] < bur_p[id])) || (mode[1] && (m_lfsr[id] < thresh));
      flip = hit ? mask : 2'b00;
      m_sym[id] = sym ^ flip;
      e.err = |flip;
      m_s[id] = (m_s[id] + 1 > cmax_p[id]) ? cmax_p[id] : m_s[id] + 1;
      m_b[id] = (m_b[id] + $countones(flip) > cmax_p[id]) ? cmax_p[id] : m_b[id] + $countones(flip);
      m_pos[id] = (m_pos[id] + 1) % per_p[id];
      m_lfsr[id] = m_lfsr[id][0] ? ((m_lfsr[id] >> 1) ^ 16'hB400) : (m_lfsr[id] >> 1);
    end
    e.valid = valid;
    e.sym   = m_sym[id];
    e.bct   = STATS ? 16'(m_b[id]) : 16'h0000;
    e.sct   = STATS ? 16'(m_s[id]) : 16'h0000;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic clr);
    exp_t e;
    exp_t g;
    @(negedge clk);
    valid = v; sym = s; clear = clr;
    for (int id = 0; id < 3; id++) model_push(id);
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      e = sb.pop_front();
      g = observe(id);
      check("datapath", id, 64'({g.valid, g.sym, g.err}), 64'({e.valid, e.sym, e.err}));
      check("counters", id, 64'({g.bct, g.sct}), 64'({e.bct, e.sct}));
    end
  endtask

  task automatic check_counts(input string name, input int id, input int b, input int s);
    exp_t g;
    g = observe(id);
    check(name, id, 64'({g.bct, g.sct}), STATS ? 64'({16'(b), 16'(s)}) : 64'd0);
  endtask

  vec_t tbl[13];
  exp_t g0;

  initial begin
    // dut_a (PERIOD=8, BURST=2), mode 01, mask 11: symbols 0,1,8,9 inverted, idles hold.
    tbl[0]  = '{1'b1, 2'b01, 2'b10, 1'b1};
    tbl[1]  = '{1'b1, 2'b00, 2'b11, 1'b1};
    tbl[2]  = '{1'b0, 2'b11, 2'b11, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 2'b10, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 2'b10, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 2'b11, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 2'b10, 2'b10, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 2'b01, 1'b1};
    tbl[11] = '{1'b1, 2'b11, 2'b00, 1'b1};
    tbl[12] = '{1'b1, 2'b11, 2'b11, 1'b0};

    valid = 1'b1; clear = 1'b0; sym = 2'b11; mode = 2'b11; mask = 2'b11; thresh = 16'hFFFF;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      g0 = observe(id);
      check("reset", id, 64'(g0), 64'd0);
    end
    @(negedge clk);
    valid = 1'b0; mode = 2'b01; thresh = 16'h0000;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].s, 1'b0);
      check("table", 0, 64'({if_a.valid_o, if_a.sym_o, if_a.err_o}), 64'({tbl[i].v, tbl[i].xs, tbl[i].xe}));
    end

    mode = 2'b00;
    for (int i = 0; i < 20; i++) step(1'($urandom_range(1, 0)), 2'($urandom), 1'b0);

    mode = 2'b10; thresh = 16'h0000;
    step(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 1000; i++) step(1'b1, 2'($urandom), 1'b0);
    check_counts("thresh0", 0, 0, 1001);

    thresh = 16'h8000;
    step(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 4095; i++) step(1'b1, 2'($urandom), 1'b0);

    mode = 2'b11; thresh = 16'h4000; mask = 2'b01;
    for (int i = 0; i < 300; i++) step(1'($urandom_range(3, 0) != 0), 2'($urandom), 1'b0);
    mask = 2'b11;
    for (int i = 0; i < 200; i++) begin
      mode = 2'($urandom);
      step(1'($urandom_range(3, 0) != 0), 2'($urandom), 1'b0);
    end

    mode = 2'b11; thresh = 16'hFFFF; mask = 2'b00;
    for (int i = 0; i < 40; i++) step(1'b1, 2'($urandom), 1'b0);

    // 256 back-to-back periodic symbols after a clear.
    mode = 2'b01; mask = 2'b11; thresh = 16'h0000;
    step(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 255; i++) step(1'b1, 2'($urandom), 1'b0);
    check_counts("period16", 2, 32, 256);
    check_counts("period8", 0, 128, 256);
    check_counts("saturate", 1, 15, 15);

    // Every other cycle valid: idles must not advance the pattern.
    step(1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 2'b10, 1'b0);
      step(1'b1, 2'($urandom), 1'b0);
    end
    check_counts("sparse", 0, 8, 16);

    // Clear coincident with the sixth symbol.
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom), 1'b0);
    step(1'b1, 2'b10, 1'b1);
    check_counts("clear", 0, 2, 1);
    check_counts("clear", 2, 2, 1);
    step(1'b1, 2'b00, 1'b0);

    // Asynchronous reset while dut_a sits in its burst window.
    step(1'b1, 2'b01, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) begin
      g0 = observe(id);
      check("async_rst", id, 64'(g0), 64'd0);
    end
    model_reset();
    @(negedge clk);
    valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 2'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/channel_err_inj.md
# channel_err_inj

Parametrised channel model between the convolutional encoder and the Viterbi decoder. It registers each W-bit coded symbol and, under runtime control, XOR-corrupts selected bits. Corruption is either a periodic burst pattern, LFSR-driven random errors, or both. Optional statistics counters report injected bit errors and symbols processed, so bit-error-rate sweeps run without testbench bookkeeping.

## Interface
- W, 2, coded symbol width in bits (≥1)
- PERIOD, 16, periodic pattern length in valid symbols (≥1)
- BURST, 1, consecutive corrupted symbols at the start of each period (0..PERIOD; 0 = periodic never corrupts)
- LFSR_SEED, 16'hACE1, reset/clear seed of the random generator (must be nonzero)
- CNT_W, 16, width of statistics counters

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  symbol strobe
- sym_i  in  W  clean symbol from encoder
- mode_i  in  2  00 pass-through, 01 periodic, 10 random, 11 periodic OR random
- err_mask_i  in  W  bits flipped when a symbol is corrupted
- thresh_i  in  16  random threshold; corrupt when lfsr < thresh_i
- clear_i  in  1  synchronous clear of pos, LFSR and counters
- valid_o  out  1  registered valid_i
- sym_o  out  W  possibly corrupted symbol
- err_o  out  1  sym_o differs from the clean symbol
- bit_err_ct_o  out  CNT_W  saturating count of flipped bits
- sym_ct_o  out  CNT_W  saturating count of valid symbols

## Operation
- pos counter, range 0..PERIOD-1: advances only on valid_i and wraps PERIOD-1→0. It advances in every mode, so the pattern stays aligned to the absolute symbol index when mode_i changes.
- Two-state FSM derived from pos:
  - BURST when pos < BURST, otherwise GAP.
  - GAP→BURST at wrap (if BURST>0).
  - BURST→GAP when pos reaches BURST.
  - BURST=PERIOD keeps the FSM in BURST permanently.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances once per valid_i in every mode; an all-zero state is unreachable.
- Corrupt decision for an accepted symbol:
  - per = (mode_i[0] && state==BURST)
  - rnd = (mode_i[1] && lfsr < thresh_i)
  - hit = per | rnd
- flip = hit ? err_mask_i : 0
- On valid_i: sym_o ← sym_i ^ flip; err_o ← |flip.
- Without valid_i: sym_o holds its value; err_o ← 0.
- thresh_i=0 never corrupts. err_mask_i=0 never corrupts, and err_o stays 0.
- Counters (if enabled):
  - sym_ct_o +1 per valid_i.
  - bit_err_ct_o + popcount(flip).
  - Both saturate at 2^CNT_W-1 and never wrap.
- clear_i: pos, LFSR (to LFSR_SEED) and counters are cleared first. A symbol in the same cycle is then processed as pos=0 with the seed value.
  - Resulting state: pos=1, counters equal to that symbol's contribution.
- mode_i, err_mask_i and thresh_i are sampled per symbol with no pipelining; changes affect the next accepted symbol.

## Timing
- Latency: one clk from valid_i/sym_i to valid_o/sym_o/err_o. Counters update in the same edge as sym_o.
- Full throughput: one symbol per cycle; there is no backpressure.
- Reset (asynchronous assert, synchronous release):
  - valid_o=0, sym_o=0, err_o=0, counters=0.
  - pos=0, FSM=BURST (or GAP if BURST=0), LFSR=LFSR_SEED.
- Reset mid-stream discards the in-flight symbol. The first symbol after release uses pos=0.
- Idle cycles (valid_i=0) freeze pos, FSM, LFSR and counters.

## Configuration
- CHANNEL_ERR_INJ_STATS_EN defined: both saturating counters are implemented as described.
- Not defined: counter registers are omitted, and bit_err_ct_o and sym_ct_o are tied to 0. Data path, FSM and LFSR are unchanged.

## Test plan
- W=2, PERIOD=16, BURST=1, mode 01, mask 2'b11, 256 consecutive symbols -> symbols 0,16,…,240 inverted, err_o on those 16 only, bit_err_ct_o=32, sym_ct_o=256.
- PERIOD=8, BURST=2, mode 01, valid_i every other cycle for 16 symbols -> symbols 0,1,8,9 corrupted; idle cycles leave pos unchanged; bit_err_ct_o=8.
- Mode 10, thresh_i=0, 1000 symbols -> no errors, bit_err_ct_o=0. Then thresh_i=16'h8000, 4096 symbols -> err count matches a reference LFSR model exactly.
- Mode 11, BURST=1, thresh_i=16'h4000 -> err_o = periodic hit OR LFSR hit on every symbol; mask 2'b01 flips only bit 0.
- CNT_W=4, mode 01, BURST=PERIOD, mask 2'b11, 20 symbols -> bit_err_ct_o saturates at 15, sym_ct_o at 15.
- clear_i with valid_i at symbol 5, then rst pulsed mid-burst -> after clear pos=1, sym_ct_o=1. After rst all outputs 0 immediately, and the next symbol is treated as pos=0.
